// File: rtl/mem_request_scheduler_pkg.sv
// Shared types for the memory request scheduler.
//   sched_state_t : scheduler FSM states
//   mem_sched_rq  : latched request (we, addr, dat, be)
//   mem_sched_rp  : registered response (id, we, addr, dat)
//   line_addr()   : byte address -> 16-byte line address
package mem_request_scheduler_pkg;

    localparam int unsigned MAX_ID_W = 3;   // enough for up to 8 requesters

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        RESP
    } sched_state_t;

    typedef struct packed {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] dat;
        logic [15:0]  be;
    } mem_sched_rq;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic                we;
        logic [31:0]         addr;
        logic [127:0]        dat;
    } mem_sched_rp;

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return {a[31:4], 4'b0000};
    endfunction

endpackage

// File: rtl/mem_request_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index (search starts here and wraps)
//   gnt : one-hot grant for the first set req at or after ptr, zero if none
// The pointer register lives in the parent.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic        found;
    logic [PW:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!found && req[idx[PW-1:0]]) begin
                gnt[idx[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_request_scheduler.sv
// Round-robin scheduler in front of a single 128-bit line memory port.
// One operation in flight at a time; partial-line writes are done as
// read-modify-write. Responses carry the requester id.
//   mclk, rst        : clock, synchronous active-high reset
//   rq_valid/ready   : per-requester request handshake (ready one-hot or 0)
//   rq_we/addr/dat/be: per-requester request payload
//   rp_valid/ready   : response handshake
//   rp_id/we/addr/dat: response payload (dat zero for write acks)
//   mem_en/re/we     : memory strobes
//   mem_addr_sel     : line address, mem_wdat: write data, mem_rdat: read data
module mem_request_scheduler #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned WR_LAT = 1,
    parameter int unsigned ID_W   = $clog2(N_REQ)
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         rq_valid,
    output logic [N_REQ-1:0]         rq_ready,
    input  logic [N_REQ-1:0]         rq_we,
    input  logic [N_REQ-1:0][31:0]   rq_addr,
    input  logic [N_REQ-1:0][127:0]  rq_dat,
    input  logic [N_REQ-1:0][15:0]   rq_be,
    output logic                     rp_valid,
    input  logic                     rp_ready,
    output logic [ID_W-1:0]          rp_id,
    output logic                     rp_we,
    output logic [31:0]              rp_addr,
    output logic [127:0]             rp_dat,
    output logic                     mem_en,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic [31:0]              mem_addr_sel,
    output logic [127:0]             mem_wdat,
    input  logic [127:0]             mem_rdat
);

    import mem_request_scheduler_pkg::*;

    // Last counter value of each wait state; wait states are skipped at latency 1.
    localparam logic [7:0] RD_LAST = (RD_LAT > 1) ? 8'(RD_LAT - 2) : 8'd0;
    localparam logic [7:0] WR_LAST = (WR_LAT > 1) ? 8'(WR_LAT - 2) : 8'd0;

    sched_state_t     state, state_nxt;
    mem_sched_rq      rq_q;
    mem_sched_rp      rp_q;
    logic             rmw_q;
    logic [7:0]       cnt_q;
    logic [127:0]     wbuf_q;
    logic [127:0]     merged;
    logic [ID_W-1:0]  rr_ptr, id_q, gnt_id;
    logic [N_REQ-1:0] gnt;

    logic             accept, rd_sample, wr_done;
    logic             sel_we;
    logic [31:0]      sel_addr;
    logic [127:0]     sel_dat;
    logic [15:0]      sel_be;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (ID_W)
    ) u_arb (
        .req (rq_valid),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    always_comb begin
        gnt_id = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id = ID_W'(i);
            end
        end
    end

    assign sel_we   = rq_we[gnt_id];
    assign sel_addr = rq_addr[gnt_id];
    assign sel_dat  = rq_dat[gnt_id];
    assign sel_be   = rq_be[gnt_id];

    assign accept    = (state == IDLE) && !rst && (|gnt);
    assign rd_sample = ((state == RD_ISSUE) && (RD_LAT == 1)) ||
                       ((state == RD_WAIT)  && (cnt_q == RD_LAST));
    assign wr_done   = ((state == WR_ISSUE) && (WR_LAT == 1)) ||
                       ((state == WR_WAIT)  && (cnt_q == WR_LAST));

    // Per-byte merge of the latched write data over the line just read.
    always_comb begin
        merged = '0;
        for (int unsigned b = 0; b < 16; b++) begin
            merged[b*8 +: 8] = rq_q.be[b] ? rq_q.dat[b*8 +: 8] : mem_rdat[b*8 +: 8];
        end
    end

    // State register
    always_ff @(posedge mclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (!sel_we) begin
                        state_nxt = RD_ISSUE;
                    end else if (sel_be == '1) begin
                        state_nxt = WR_ISSUE;
                    end else if (sel_be == '0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                if (rd_sample) begin
                    state_nxt = rmw_q ? WR_ISSUE : RESP;
                end else begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_sample) begin
                    state_nxt = rmw_q ? WR_ISSUE : RESP;
                end
            end
            WR_ISSUE: state_nxt = wr_done ? RESP : WR_WAIT;
            WR_WAIT: begin
                if (wr_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        rq_ready     = '0;
        mem_en       = 1'b0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = '0;
        mem_wdat     = '0;
        rp_valid     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst) begin
                    rq_ready = gnt;
                end
            end
            RD_ISSUE: begin
                mem_en       = 1'b1;
                mem_re       = 1'b1;
                mem_addr_sel = line_addr(rq_q.addr);
            end
            WR_ISSUE: begin
                mem_en       = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = line_addr(rq_q.addr);
                mem_wdat     = wbuf_q;
            end
            RESP:    rp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rp_id   = rp_q.id[ID_W-1:0];
    assign rp_we   = rp_q.we;
    assign rp_addr = rp_q.addr;
    assign rp_dat  = rp_q.dat;

    // Datapath registers
    always_ff @(posedge mclk) begin
        if (rst) begin
            rr_ptr <= '0;
            id_q   <= '0;
            rq_q   <= '0;
            rmw_q  <= 1'b0;
            cnt_q  <= '0;
            wbuf_q <= '0;
            rp_q   <= '0;
        end else begin
            if ((state == RD_ISSUE) || (state == WR_ISSUE)) begin
                cnt_q <= '0;
            end else if ((state == RD_WAIT) || (state == WR_WAIT)) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (accept) begin
                rq_q   <= '{we: sel_we, addr: sel_addr, dat: sel_dat, be: sel_be};
                id_q   <= gnt_id;
                rr_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
                wbuf_q <= sel_dat;
                rmw_q  <= sel_we && (sel_be != '0) && (sel_be != '1);
                // Empty-mask write: acknowledged straight away, memory untouched.
                if (sel_we && (sel_be == '0)) begin
                    rp_q <= '{id: MAX_ID_W'(gnt_id), we: 1'b1, addr: sel_addr, dat: '0};
                end
            end

            if (rd_sample) begin
                if (rmw_q) begin
                    wbuf_q <= merged;
                end else begin
                    rp_q <= '{id: MAX_ID_W'(id_q), we: 1'b0, addr: rq_q.addr, dat: mem_rdat};
                end
            end

            if (wr_done) begin
                rp_q <= '{id: MAX_ID_W'(id_q), we: 1'b1, addr: rq_q.addr, dat: '0};
            end
        end
    end

endmodule

// File: tb/tb_mem_request_scheduler.sv
// Directed bench for mem_request_scheduler with a simple line-memory model.
module tb_mem_request_scheduler;

    localparam logic [127:0] A5_LINE   = {16{8'hA5}};
    localparam logic [127:0] ONES_LINE = {16{8'h11}};
    localparam logic [127:0] RMW_EXP   = {{12{8'h11}}, 32'hDEADBEEF};
    localparam logic [127:0] DFLT_LINE = {4{32'hC0FFEE00}};
    localparam logic [127:0] JUNK_LINE = {4{32'hBAADBAAD}};
    localparam logic [127:0] W_DAT     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic               mclk = 1'b0;
    logic               rst  = 1'b1;
    logic [3:0]         rq_valid = '0;
    logic [3:0]         rq_ready;
    logic [3:0]         rq_we = '0;
    logic [3:0][31:0]   rq_addr = '0;
    logic [3:0][127:0]  rq_dat = '0;
    logic [3:0][15:0]   rq_be = '0;
    logic               rp_valid;
    logic               rp_ready = 1'b0;
    logic [1:0]         rp_id;
    logic               rp_we;
    logic [31:0]        rp_addr;
    logic [127:0]       rp_dat;
    logic               mem_en, mem_re, mem_we;
    logic [31:0]        mem_addr_sel;
    logic [127:0]       mem_wdat;
    logic [127:0]       mem_rdat = JUNK_LINE;

    logic [127:0]       mem_model [0:63];
    int                 tests_run = 0;
    int                 fails = 0;
    int                 both_err = 0, en_err = 0, multi_err = 0, resp_count = 0;
    int                 grant_q[$];

    always #5 mclk = ~mclk;

    mem_request_scheduler #(
        .N_REQ  (4),
        .RD_LAT (2),
        .WR_LAT (1)
    ) dut (
        .mclk         (mclk),
        .rst          (rst),
        .rq_valid     (rq_valid),
        .rq_ready     (rq_ready),
        .rq_we        (rq_we),
        .rq_addr      (rq_addr),
        .rq_dat       (rq_dat),
        .rq_be        (rq_be),
        .rp_valid     (rp_valid),
        .rp_ready     (rp_ready),
        .rp_id        (rp_id),
        .rp_we        (rp_we),
        .rp_addr      (rp_addr),
        .rp_dat       (rp_dat),
        .mem_en       (mem_en),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .mem_wdat     (mem_wdat),
        .mem_rdat     (mem_rdat)
    );

    initial begin
        for (int i = 0; i < 64; i++) mem_model[i] = DFLT_LINE;
        mem_model[4]  = A5_LINE;     // line 0x040
        mem_model[16] = ONES_LINE;   // line 0x100
    end

    // Memory model: data for a read issued in cycle E0..E1 is presented from
    // E1 to E2 only (RD_LAT=2); any other cycle carries junk.
    always @(posedge mclk) begin
        if (mem_re && mem_we) both_err <= both_err + 1;
        if (mem_en != (mem_re | mem_we)) en_err <= en_err + 1;
        if ($countones(rq_ready) > 1) multi_err <= multi_err + 1;
        if (rp_valid && rp_ready) resp_count <= resp_count + 1;
        for (int i = 0; i < 4; i++) begin
            if (rq_valid[i] && rq_ready[i]) grant_q.push_back(i);
        end
        if (mem_en && mem_we) mem_model[mem_addr_sel[9:4]] <= mem_wdat;
        if (mem_en && mem_re) mem_rdat <= mem_model[mem_addr_sel[9:4]];
        else                  mem_rdat <= JUNK_LINE;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time bound expired");
        $fatal(1, "watchdog");
    end

    // Presents a request and returns just after its acceptance edge.
    task automatic drive_req(input logic [1:0] idx, input logic we, input logic [31:0] addr,
                             input logic [127:0] dat, input logic [15:0] be, output bit ok);
        int n;
        @(negedge mclk);
        rq_we[idx] = we; rq_addr[idx] = addr; rq_dat[idx] = dat; rq_be[idx] = be;
        rq_valid[idx] = 1'b1;
        #1;
        n = 0;
        while (!rq_ready[idx] && n < 50) begin
            @(negedge mclk); #1; n++;
        end
        ok = rq_ready[idx];
        @(posedge mclk);
        #1 rq_valid[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rq_valid = '1; rp_ready = 1'b0;
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        tests_run++;
        if (rq_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_rq_ready: got %b expected 0000", rq_ready);
        end
        tests_run++;
        if (rp_valid !== 1'b0 || rp_we !== 1'b0 || rp_id !== 2'd0 || rp_addr !== 32'd0 || rp_dat !== 128'd0) begin
            fails++; $display("FAIL reset_rp: got v=%b we=%b id=%0d addr=%h dat=%h expected all zero",
                              rp_valid, rp_we, rp_id, rp_addr, rp_dat);
        end
        tests_run++;
        if (mem_en !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0 || mem_addr_sel !== 32'd0 || mem_wdat !== 128'd0) begin
            fails++; $display("FAIL reset_mem: got en=%b re=%b we=%b addr=%h expected all zero",
                              mem_en, mem_re, mem_we, mem_addr_sel);
        end
        rq_valid = '0; rst = 1'b0;
    endtask

    task automatic test_read();
        bit ok; int first_c; logic [9:0] re_m, we_m;
        logic [31:0] a_sel, c_addr; logic [1:0] c_id; logic c_we; logic [127:0] c_dat;
        rp_ready = 1'b1;
        drive_req(2'd0, 1'b0, 32'h0000_0040, '0, '0, ok);
        tests_run++;
        if (!ok) begin fails++; $display("FAIL read_grant: got no rq_ready[0] expected grant"); end
        first_c = -1; re_m = '0; we_m = '0; a_sel = '0;
        c_addr = '0; c_id = '0; c_we = 1'b1; c_dat = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge mclk);
            re_m |= 10'(mem_re) << c;
            we_m |= 10'(mem_we) << c;
            if (mem_re) a_sel = mem_addr_sel;
            if (rp_valid && first_c < 0) begin
                first_c = c; c_id = rp_id; c_we = rp_we; c_addr = rp_addr; c_dat = rp_dat;
            end
        end
        tests_run++;
        if (first_c != 2) begin fails++; $display("FAIL read_latency: got %0d expected 2", first_c); end
        tests_run++;
        if (re_m !== 10'b1 || we_m !== 10'b0) begin
            fails++; $display("FAIL read_strobes: got re=%b we=%b expected re=0000000001 we=0", re_m, we_m);
        end
        tests_run++;
        if (a_sel !== 32'h40) begin fails++; $display("FAIL read_addr_sel: got %h expected 00000040", a_sel); end
        tests_run++;
        if (c_id !== 2'd0 || c_we !== 1'b0 || c_addr !== 32'h40 || c_dat !== A5_LINE) begin
            fails++; $display("FAIL read_resp: got id=%0d we=%b addr=%h dat=%h expected id=0 we=0 addr=40 dat=%h",
                              c_id, c_we, c_addr, c_dat, A5_LINE);
        end
    endtask

    task automatic test_rmw();
        bit ok; int first_c; logic [9:0] re_m, we_m;
        logic [31:0] w_addr; logic [127:0] w_dat; logic [1:0] c_id; logic c_we; logic [127:0] c_dat;
        rp_ready = 1'b1;
        drive_req(2'd1, 1'b1, 32'h0000_0100, {{12{8'hCC}}, 32'hDEADBEEF}, 16'h000F, ok);
        tests_run++;
        if (!ok) begin fails++; $display("FAIL rmw_grant: got no rq_ready[1] expected grant"); end
        first_c = -1; re_m = '0; we_m = '0; w_addr = '0; w_dat = '0;
        c_id = '0; c_we = 1'b0; c_dat = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge mclk);
            re_m |= 10'(mem_re) << c;
            we_m |= 10'(mem_we) << c;
            if (mem_we) begin w_addr = mem_addr_sel; w_dat = mem_wdat; end
            if (rp_valid && first_c < 0) begin
                first_c = c; c_id = rp_id; c_we = rp_we; c_dat = rp_dat;
            end
        end
        tests_run++;
        if (re_m !== 10'b0000000001 || we_m !== 10'b0000000100) begin
            fails++; $display("FAIL rmw_strobes: got re=%b we=%b expected re=0000000001 we=0000000100", re_m, we_m);
        end
        tests_run++;
        if (w_addr !== 32'h100 || w_dat !== RMW_EXP) begin
            fails++; $display("FAIL rmw_wdata: got addr=%h dat=%h expected addr=00000100 dat=%h", w_addr, w_dat, RMW_EXP);
        end
        tests_run++;
        if (first_c != 3) begin fails++; $display("FAIL rmw_latency: got %0d expected 3", first_c); end
        tests_run++;
        if (c_id !== 2'd1 || c_we !== 1'b1 || c_dat !== 128'd0) begin
            fails++; $display("FAIL rmw_ack: got id=%0d we=%b dat=%h expected id=1 we=1 dat=0", c_id, c_we, c_dat);
        end
    endtask

    task automatic test_full_write();
        bit ok; int first_c; logic [9:0] re_m, we_m;
        logic [31:0] w_addr, c_addr; logic [127:0] w_dat, c_dat; logic [1:0] c_id; logic c_we;
        rp_ready = 1'b1;
        drive_req(2'd2, 1'b1, 32'h0000_0208, W_DAT, 16'hFFFF, ok);
        tests_run++;
        if (!ok) begin fails++; $display("FAIL fullwr_grant: got no rq_ready[2] expected grant"); end
        first_c = -1; re_m = '0; we_m = '0; w_addr = '0; w_dat = '0;
        c_id = '0; c_we = 1'b0; c_addr = '0; c_dat = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge mclk);
            re_m |= 10'(mem_re) << c;
            we_m |= 10'(mem_we) << c;
            if (mem_we) begin w_addr = mem_addr_sel; w_dat = mem_wdat; end
            if (rp_valid && first_c < 0) begin
                first_c = c; c_id = rp_id; c_we = rp_we; c_addr = rp_addr; c_dat = rp_dat;
            end
        end
        tests_run++;
        if (re_m !== 10'b0 || we_m !== 10'b1) begin
            fails++; $display("FAIL fullwr_strobes: got re=%b we=%b expected re=0 we=0000000001", re_m, we_m);
        end
        tests_run++;
        if (w_addr !== 32'h200 || w_dat !== W_DAT) begin
            fails++; $display("FAIL fullwr_wdata: got addr=%h dat=%h expected addr=00000200 dat=%h", w_addr, w_dat, W_DAT);
        end
        tests_run++;
        if (first_c != 1) begin fails++; $display("FAIL fullwr_latency: got %0d expected 1", first_c); end
        tests_run++;
        if (c_id !== 2'd2 || c_we !== 1'b1 || c_addr !== 32'h208 || c_dat !== 128'd0) begin
            fails++; $display("FAIL fullwr_ack: got id=%0d we=%b addr=%h dat=%h expected id=2 we=1 addr=208 dat=0",
                              c_id, c_we, c_addr, c_dat);
        end
    endtask

    task automatic test_zero_be();
        bit ok; int first_c; logic [9:0] en_m; logic [1:0] c_id; logic c_we; logic [127:0] c_dat;
        rp_ready = 1'b1;
        drive_req(2'd3, 1'b1, 32'h0000_0300, W_DAT, 16'h0000, ok);
        tests_run++;
        if (!ok) begin fails++; $display("FAIL zerobe_grant: got no rq_ready[3] expected grant"); end
        first_c = -1; en_m = '0; c_id = '0; c_we = 1'b0; c_dat = '1;
        for (int c = 0; c < 6; c++) begin
            @(negedge mclk);
            en_m |= 10'(mem_en) << c;
            if (rp_valid && first_c < 0) begin
                first_c = c; c_id = rp_id; c_we = rp_we; c_dat = rp_dat;
            end
        end
        tests_run++;
        if (en_m !== 10'b0) begin fails++; $display("FAIL zerobe_no_mem: got en=%b expected 0", en_m); end
        tests_run++;
        if (first_c != 0) begin fails++; $display("FAIL zerobe_latency: got %0d expected 0", first_c); end
        tests_run++;
        if (c_id !== 2'd3 || c_we !== 1'b1 || c_dat !== 128'd0) begin
            fails++; $display("FAIL zerobe_ack: got id=%0d we=%b dat=%h expected id=3 we=1 dat=0", c_id, c_we, c_dat);
        end
    endtask

    task automatic test_backpressure();
        bit ok; int n, unstable, early; logic [1:0] c_id; logic c_we; logic [31:0] c_addr; logic [127:0] c_dat;
        rp_ready = 1'b0;
        drive_req(2'd0, 1'b0, 32'h0000_0040, '0, '0, ok);
        rq_we[1] = 1'b0; rq_addr[1] = 32'h0000_0100; rq_valid[1] = 1'b1;
        n = 0;
        do begin @(negedge mclk); n++; end while (!rp_valid && n < 10);
        tests_run++;
        if (!ok || rp_valid !== 1'b1) begin
            fails++; $display("FAIL bp_resp_present: got rp_valid=%b ok=%0d expected 1", rp_valid, ok);
        end
        c_id = rp_id; c_we = rp_we; c_addr = rp_addr; c_dat = rp_dat;
        unstable = 0; early = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge mclk);
            if (rp_valid !== 1'b1 || rp_id !== c_id || rp_we !== c_we || rp_addr !== c_addr || rp_dat !== c_dat)
                unstable++;
            if (rq_ready !== 4'b0000) early++;
        end
        tests_run++;
        if (unstable != 0 || c_dat !== A5_LINE || c_id !== 2'd0) begin
            fails++; $display("FAIL bp_hold: got %0d unstable cycles, dat=%h id=%0d expected 0, %h, 0",
                              unstable, c_dat, c_id, A5_LINE);
        end
        tests_run++;
        if (early != 0) begin fails++; $display("FAIL bp_no_ready: got %0d cycles with rq_ready expected 0", early); end
        rp_ready = 1'b1;
        @(negedge mclk);
        tests_run++;
        if (rp_valid !== 1'b0 || rq_ready !== 4'b0010) begin
            fails++; $display("FAIL bp_release: got rp_valid=%b rq_ready=%b expected 0 and 0010", rp_valid, rq_ready);
        end
        @(posedge mclk);
        #1 rq_valid[1] = 1'b0;
        n = 0;
        do begin @(negedge mclk); n++; end while (!rp_valid && n < 10);
        tests_run++;
        if (rp_valid !== 1'b1 || rp_id !== 2'd1 || rp_addr !== 32'h100 || rp_dat !== RMW_EXP) begin
            fails++; $display("FAIL bp_next_read: got v=%b id=%0d addr=%h dat=%h expected v=1 id=1 addr=100 dat=%h",
                              rp_valid, rp_id, rp_addr, rp_dat, RMW_EXP);
        end
        @(negedge mclk);
    endtask

    task automatic test_round_robin();
        int n; int exp_g[5];
        exp_g = '{0, 1, 2, 3, 0};
        @(negedge mclk); rst = 1'b1;
        @(negedge mclk); rst = 1'b0;
        grant_q.delete();
        rp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rq_we[i] = 1'b0; rq_addr[i] = 32'(i * 16);
        end
        rq_valid = 4'b1111;
        n = 0;
        while (grant_q.size() < 5 && n < 100) begin @(negedge mclk); n++; end
        rq_valid = '0;
        repeat (8) @(negedge mclk);
        tests_run++;
        if (grant_q.size() < 5) begin
            fails++; $display("FAIL rr_count: got %0d grants expected at least 5", grant_q.size());
        end
        for (int k = 0; k < 5; k++) begin
            if (k < grant_q.size()) begin
                tests_run++;
                if (grant_q[k] != exp_g[k]) begin
                    fails++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, grant_q[k], exp_g[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit ok; int n, seen, resp_before;
        rp_ready = 1'b1;
        drive_req(2'd2, 1'b0, 32'h0000_0040, '0, '0, ok);
        @(negedge mclk);             // RD_ISSUE
        @(negedge mclk);             // RD_WAIT
        rst = 1'b1;
        resp_before = resp_count;
        @(negedge mclk);
        tests_run++;
        if (!ok || rp_valid !== 1'b0 || rp_id !== 2'd0 || rp_addr !== 32'd0 || rp_dat !== 128'd0 ||
            mem_en !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0 || rq_ready !== 4'b0000) begin
            fails++; $display("FAIL midrst_outputs: got ok=%0d rp_valid=%b rp_dat=%h mem_en=%b rq_ready=%b expected all zero",
                              ok, rp_valid, rp_dat, mem_en, rq_ready);
        end
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge mclk);
            if (rp_valid) seen++;
        end
        tests_run++;
        if (seen != 0 || resp_count != resp_before) begin
            fails++; $display("FAIL midrst_dropped: got %0d valid cycles, %0d responses expected 0, 0",
                              seen, resp_count - resp_before);
        end
        rq_we[2] = 1'b0; rq_addr[2] = 32'h40;
        rq_we[3] = 1'b0; rq_addr[3] = 32'h40;
        rq_valid = 4'b1100;
        #1;
        tests_run++;
        if (rq_ready !== 4'b0100) begin fails++; $display("FAIL midrst_ptr: got rq_ready=%b expected 0100", rq_ready); end
        @(posedge mclk);
        #1 rq_valid = '0;
        n = 0;
        do begin @(negedge mclk); n++; end while (!rp_valid && n < 10);
        tests_run++;
        if (rp_valid !== 1'b1 || rp_id !== 2'd2 || rp_dat !== A5_LINE) begin
            fails++; $display("FAIL midrst_fresh: got v=%b id=%0d dat=%h expected v=1 id=2 dat=%h",
                              rp_valid, rp_id, rp_dat, A5_LINE);
        end
        @(negedge mclk);
    endtask

    task automatic test_invariants();
        tests_run++;
        if (both_err != 0) begin fails++; $display("FAIL inv_re_we: got %0d overlapping cycles expected 0", both_err); end
        tests_run++;
        if (en_err != 0) begin fails++; $display("FAIL inv_mem_en: got %0d bad cycles expected 0", en_err); end
        tests_run++;
        if (multi_err != 0) begin fails++; $display("FAIL inv_onehot: got %0d multi-grant cycles expected 0", multi_err); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_rmw();
        test_full_write();
        test_zero_be();
        test_backpressure();
        test_round_robin();
        test_reset_midflight();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
